// File: rtl/decode_issue_stage_pkg.sv
// Shared types and helpers for the RV32 decode/issue stage: instruction and
// control layouts, encoding classes, immediate extraction and source-use map.
package decode_issue_stage_pkg;

  typedef enum logic [2:0] {
    R_TYPE,
    I_TYPE,
    S_TYPE,
    B_TYPE,
    U_TYPE,
    J_TYPE
  } encoding_type;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } instruction_type;

  typedef struct packed {
    encoding_type encoding;
    logic         reg_write;
    logic         mem_read;
    logic         mem_write;
    logic         is_branch;
  } control_type;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // 32-bit sign-extended immediate for the given encoding; R-type has none.
  function automatic logic [31:0] immediate_extension(instruction_type instr,
                                                      encoding_type    enc);
    logic [31:0] w;
    logic [31:0] imm;
    w = instr;
    case (enc)
      I_TYPE:  imm = {{20{w[31]}}, w[31:20]};
      S_TYPE:  imm = {{20{w[31]}}, w[31:25], w[11:7]};
      B_TYPE:  imm = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      U_TYPE:  imm = {w[31:12], 12'b0};
      J_TYPE:  imm = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

  // Which source fields the encoding actually reads: {rs1_used, rs2_used}.
  function automatic logic [1:0] rs_used(encoding_type enc);
    logic [1:0] used;
    case (enc)
      R_TYPE, S_TYPE, B_TYPE: used = 2'b11;
      I_TYPE:                 used = 2'b10;
      default:                used = 2'b00;
    endcase
    return used;
  endfunction

endpackage

// File: rtl/decode_issue_stage_if.sv
// Fetch-side and execute-side handshakes of the decode/issue stage.
// master = environment (fetch + execute), slave = the stage itself.
interface decode_issue_stage_if #(
  parameter int XLEN = 32
);
  import decode_issue_stage_pkg::*;

  logic            in_valid;
  logic            in_ready;
  instruction_type instruction;
  logic [XLEN-1:0] pc_in;

  logic            out_valid;
  logic            out_ready;
  logic [4:0]      rd_id;
  logic [4:0]      rs1_id;
  logic [4:0]      rs2_id;
  logic [XLEN-1:0] read_data1;
  logic [XLEN-1:0] read_data2;
  logic [XLEN-1:0] immediate_data;
  logic [XLEN-1:0] pc_out;
  control_type     control_signals;
  logic            instruction_illegal;

  modport master (
    output in_valid, instruction, pc_in, out_ready,
    input  in_ready, out_valid, rd_id, rs1_id, rs2_id, read_data1, read_data2,
           immediate_data, pc_out, control_signals, instruction_illegal
  );

  modport slave (
    input  in_valid, instruction, pc_in, out_ready,
    output in_ready, out_valid, rd_id, rs1_id, rs2_id, read_data1, read_data2,
           immediate_data, pc_out, control_signals, instruction_illegal
  );
endinterface

// File: rtl/control.sv
// Opcode decoder: encoding class and the four datapath controls.
module control
  import decode_issue_stage_pkg::*;
(
  input  logic [6:0]  opcode,
  output control_type control_signals,
  output logic        decode_failed
);

  // Map each RV32I major opcode onto its encoding and controls
  always_comb begin
    control_signals          = '0;
    control_signals.encoding = R_TYPE;
    decode_failed            = 1'b0;
    case (opcode)
      OPC_OP: begin
        control_signals.encoding  = R_TYPE;
        control_signals.reg_write = 1'b1;
      end
      OPC_OP_IMM: begin
        control_signals.encoding  = I_TYPE;
        control_signals.reg_write = 1'b1;
      end
      OPC_LOAD: begin
        control_signals.encoding  = I_TYPE;
        control_signals.reg_write = 1'b1;
        control_signals.mem_read  = 1'b1;
      end
      OPC_STORE: begin
        control_signals.encoding  = S_TYPE;
        control_signals.mem_write = 1'b1;
      end
      OPC_BRANCH: begin
        control_signals.encoding  = B_TYPE;
        control_signals.is_branch = 1'b1;
      end
      OPC_LUI, OPC_AUIPC: begin
        control_signals.encoding  = U_TYPE;
        control_signals.reg_write = 1'b1;
      end
      OPC_JAL: begin
        control_signals.encoding  = J_TYPE;
        control_signals.reg_write = 1'b1;
        control_signals.is_branch = 1'b1;
      end
      OPC_JALR: begin
        control_signals.encoding  = I_TYPE;
        control_signals.reg_write = 1'b1;
        control_signals.is_branch = 1'b1;
      end
      default: decode_failed = 1'b1;
    endcase
  end

endmodule

// File: rtl/decode_issue_stage_hazard.sv
// Load-use hazard detection against the held instruction, the upstream
// ready, and a saturating count of cycles spent stalled on a hazard.
module decode_hazard_unit #(
  parameter bit LOAD_USE_STALL = 1'b1,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             flush,
  input  logic             out_valid,
  input  logic             out_ready,
  input  logic             held_mem_read,
  input  logic [4:0]       held_rd_id,
  input  logic [4:0]       rs1_id,
  input  logic [4:0]       rs2_id,
  input  logic [1:0]       rs_used_bits,
  output logic             in_ready,
  output logic [CNT_W-1:0] stall_cycles
);

  logic hazard;

  // A flush kills the load anyway, so the hazard is ignored while it is asserted
  always_comb begin
    hazard = LOAD_USE_STALL && out_valid && held_mem_read && held_rd_id != 5'd0 &&
             ((rs_used_bits[1] && rs1_id == held_rd_id) ||
              (rs_used_bits[0] && rs2_id == held_rd_id));
    in_ready = !reset && (!out_valid || out_ready) && (!hazard || flush);
  end

  // Saturating stall-cycle counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (in_valid && hazard && !flush && stall_cycles != '1) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: rtl/register_file.sv
// Architectural register file: two combinational reads, one write port.
// x0 and ids beyond NUM_REGS read as zero; writes to them are dropped.
module register_file #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            write_en,
  input  logic [4:0]      write_id,
  input  logic [XLEN-1:0] write_data,
  input  logic [4:0]      read_id1,
  input  logic [4:0]      read_id2,
  output logic [XLEN-1:0] read_data1,
  output logic [XLEN-1:0] read_data2
);

  localparam int         IDX_W     = $clog2(NUM_REGS);
  localparam logic [5:0] REG_LIMIT = 6'(NUM_REGS);

  logic [XLEN-1:0] regs [NUM_REGS];

  // Register storage, cleared on reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (write_en && write_id != 5'd0 && {1'b0, write_id} < REG_LIMIT) begin
      regs[write_id[IDX_W-1:0]] <= write_data;
    end
  end

  // Combinational reads with x0 and out-of-range ids forced to zero
  always_comb begin
    read_data1 = '0;
    read_data2 = '0;
    if (read_id1 != 5'd0 && {1'b0, read_id1} < REG_LIMIT) read_data1 = regs[read_id1[IDX_W-1:0]];
    if (read_id2 != 5'd0 && {1'b0, read_id2} < REG_LIMIT) read_data2 = regs[read_id2[IDX_W-1:0]];
  end

endmodule

// File: rtl/decode_issue_stage.sv
// Registered RV32 decode/issue stage: decodes one instruction per cycle,
// reads operands with write-back forwarding, screens illegal encodings and
// holds the decoded bundle in the ID/EX output register.
module decode_issue_stage
  import decode_issue_stage_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int NUM_REGS       = 32,
  parameter bit BYPASS_EN      = 1'b1,
  parameter bit LOAD_USE_STALL = 1'b1,
  parameter int CNT_W          = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  decode_issue_stage_if.slave  bus,
  input  logic                 flush,
  input  logic                 wb_write_en,
  input  logic [4:0]           wb_write_id,
  input  logic [XLEN-1:0]      wb_write_data,
  output logic [CNT_W-1:0]     stall_cycles
);

  localparam logic [5:0] REG_LIMIT = 6'(NUM_REGS);

  instruction_type ins;
  control_type     dec_ctl;
  control_type     ctl_d;
  logic            decode_failed;
  logic [1:0]      used;
  logic            rd_checked;
  logic            illegal_d;
  logic            accept;
  logic [XLEN-1:0] rf_data1;
  logic [XLEN-1:0] rf_data2;
  logic [XLEN-1:0] rd1_d;
  logic [XLEN-1:0] rd2_d;
  logic [XLEN-1:0] imm_d;

  assign ins    = bus.instruction;
  assign used   = rs_used(dec_ctl.encoding);
  assign accept = bus.in_valid && bus.in_ready;

  control u_control (
    .opcode          (ins.opcode),
    .control_signals (dec_ctl),
    .decode_failed   (decode_failed)
  );

  register_file #(
    .XLEN     (XLEN),
    .NUM_REGS (NUM_REGS)
  ) u_register_file (
    .clk        (clk),
    .reset      (reset),
    .write_en   (wb_write_en),
    .write_id   (wb_write_id),
    .write_data (wb_write_data),
    .read_id1   (ins.rs1),
    .read_id2   (ins.rs2),
    .read_data1 (rf_data1),
    .read_data2 (rf_data2)
  );

  decode_hazard_unit #(
    .LOAD_USE_STALL (LOAD_USE_STALL),
    .CNT_W          (CNT_W)
  ) u_hazard (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (bus.in_valid),
    .flush         (flush),
    .out_valid     (bus.out_valid),
    .out_ready     (bus.out_ready),
    .held_mem_read (bus.control_signals.mem_read),
    .held_rd_id    (bus.rd_id),
    .rs1_id        (ins.rs1),
    .rs2_id        (ins.rs2),
    .rs_used_bits  (used),
    .in_ready      (bus.in_ready),
    .stall_cycles  (stall_cycles)
  );

  // Operand forwarding, illegal screening and masking of side-effecting controls
  always_comb begin
    rd1_d = rf_data1;
    rd2_d = rf_data2;
    if (BYPASS_EN && wb_write_en && ins.rs1 != 5'd0 && wb_write_id == ins.rs1) rd1_d = wb_write_data;
    if (BYPASS_EN && wb_write_en && ins.rs2 != 5'd0 && wb_write_id == ins.rs2) rd2_d = wb_write_data;

    rd_checked = (dec_ctl.encoding != S_TYPE) && (dec_ctl.encoding != B_TYPE);
    illegal_d  = decode_failed ||
                 (rd_checked && {1'b0, ins.rd} >= REG_LIMIT) ||
                 (used[1] && {1'b0, ins.rs1} >= REG_LIMIT) ||
                 (used[0] && {1'b0, ins.rs2} >= REG_LIMIT);

    ctl_d = dec_ctl;
    if (illegal_d) begin
      ctl_d.reg_write = 1'b0;
      ctl_d.mem_read  = 1'b0;
      ctl_d.mem_write = 1'b0;
      ctl_d.is_branch = 1'b0;
    end

    imm_d = XLEN'($signed(immediate_extension(ins, dec_ctl.encoding)));
  end

  // ID/EX output register: flush beats accept, accept beats drain
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.out_valid           <= 1'b0;
      bus.rd_id               <= '0;
      bus.rs1_id              <= '0;
      bus.rs2_id              <= '0;
      bus.read_data1          <= '0;
      bus.read_data2          <= '0;
      bus.immediate_data      <= '0;
      bus.pc_out              <= '0;
      bus.control_signals     <= '0;
      bus.instruction_illegal <= 1'b0;
    end else if (flush) begin
      bus.out_valid <= 1'b0;
    end else if (accept) begin
      bus.out_valid           <= 1'b1;
      bus.rd_id               <= ins.rd;
      bus.rs1_id              <= ins.rs1;
      bus.rs2_id              <= ins.rs2;
      bus.read_data1          <= rd1_d;
      bus.read_data2          <= rd2_d;
      bus.immediate_data      <= imm_d;
      bus.pc_out              <= bus.pc_in;
      bus.control_signals     <= ctl_d;
      bus.instruction_illegal <= illegal_d;
    end else if (bus.out_ready) begin
      bus.out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_issue_stage.sv
// Directed bench for decode_issue_stage: dut_a uses default parameters,
// dut_b is RV32E without forwarding and a 2-bit stall counter.
module tb_decode_issue_stage;
  import decode_issue_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        wb_write_en;
  logic [4:0]  wb_write_id;
  logic [31:0] wb_write_data;
  logic [31:0] stall_a;
  logic [1:0]  stall_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  decode_issue_stage_if #(.XLEN(32)) bus_a ();
  decode_issue_stage_if #(.XLEN(32)) bus_b ();

  decode_issue_stage dut_a (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus_a),
    .flush         (flush),
    .wb_write_en   (wb_write_en),
    .wb_write_id   (wb_write_id),
    .wb_write_data (wb_write_data),
    .stall_cycles  (stall_a)
  );

  decode_issue_stage #(
    .NUM_REGS  (16),
    .BYPASS_EN (1'b0),
    .CNT_W     (2)
  ) dut_b (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus_b),
    .flush         (flush),
    .wb_write_en   (wb_write_en),
    .wb_write_id   (wb_write_id),
    .wb_write_data (wb_write_data),
    .stall_cycles  (stall_b)
  );

  typedef struct {
    logic        v;
    logic [31:0] ins;
    logic [31:0] pc;
    logic        fl;
    logic        we;
    logic [4:0]  wid;
    logic [31:0] wd;
    logic        e_rdy;
    logic        e_ov;
    logic [4:0]  e_rd;
    logic [31:0] e_imm;
    logic [31:0] e_rd1;
    logic [31:0] e_rd2;
    logic [31:0] e_rd2_b;
    logic        e_ill;
    logic        e_ill_b;
    logic        e_rw;
    logic        e_rw_b;
    logic [31:0] e_stall;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic rdy, input logic fl, input logic we,
                       input logic [4:0] wid, input logic [31:0] wd);
    bus_a.in_valid    = v;
    bus_b.in_valid    = v;
    bus_a.instruction = ins;
    bus_b.instruction = ins;
    bus_a.pc_in       = pc;
    bus_b.pc_in       = pc;
    bus_a.out_ready   = rdy;
    bus_b.out_ready   = rdy;
    flush             = fl;
    wb_write_en       = we;
    wb_write_id       = wid;
    wb_write_data     = wd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] ADD_3_2_1 = 32'h001101B3;
  localparam logic [31:0] LW_2_0_1  = 32'h0000A103;

  initial begin
    //           v  ins           pc     fl we wid wd            rdy ov rd  imm           rd1           rd2           rd2_b         il ilb rw rwb stall
    vecs[0]  = '{0, 32'h0,        32'h0,   0, 1, 1, 32'h11111111, 1, 0, 0,  32'h0,        32'h0,        32'h0,        32'h0,        0, 0, 0, 0, 0};
    vecs[1]  = '{0, 32'h0,        32'h0,   0, 1, 2, 32'h22222222, 1, 0, 0,  32'h0,        32'h0,        32'h0,        32'h0,        0, 0, 0, 0, 0};
    vecs[2]  = '{1, 32'h00500093, 32'h100, 0, 0, 0, 32'h0,        1, 1, 1,  32'h5,        32'h0,        32'h0,        32'h0,        0, 0, 1, 1, 0};
    vecs[3]  = '{1, ADD_3_2_1,    32'h104, 0, 1, 1, 32'hDEADBEEF, 1, 1, 3,  32'h0,        32'h22222222, 32'hDEADBEEF, 32'h11111111, 0, 0, 1, 1, 0};
    vecs[4]  = '{1, LW_2_0_1,     32'h108, 0, 0, 0, 32'h0,        1, 1, 2,  32'h0,        32'hDEADBEEF, 32'h0,        32'h0,        0, 0, 1, 1, 0};
    vecs[5]  = '{1, ADD_3_2_1,    32'h10C, 0, 0, 0, 32'h0,        0, 0, 0,  32'h0,        32'h0,        32'h0,        32'h0,        0, 0, 0, 0, 1};
    vecs[6]  = '{1, ADD_3_2_1,    32'h10C, 0, 0, 0, 32'h0,        1, 1, 3,  32'h0,        32'h22222222, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 1, 1, 1};
    vecs[7]  = '{1, 32'h002088B3, 32'h110, 0, 0, 0, 32'h0,        1, 1, 17, 32'h0,        32'hDEADBEEF, 32'h22222222, 32'h22222222, 0, 1, 1, 0, 1};
    vecs[8]  = '{1, 32'h00000013, 32'h114, 0, 0, 0, 32'h0,        1, 1, 0,  32'h0,        32'h0,        32'h0,        32'h0,        0, 0, 1, 1, 1};
    vecs[9]  = '{1, 32'hFFF08213, 32'h118, 0, 0, 0, 32'h0,        1, 1, 4,  32'hFFFFFFFF, 32'hDEADBEEF, 32'h0,        32'h0,        0, 0, 1, 1, 1};
    vecs[10] = '{1, 32'hFE20AE23, 32'h11C, 0, 0, 0, 32'h0,        1, 1, 28, 32'hFFFFFFFC, 32'hDEADBEEF, 32'h22222222, 32'h22222222, 0, 0, 0, 0, 1};
    vecs[11] = '{1, 32'hFFFFFFFF, 32'h120, 0, 0, 0, 32'h0,        1, 1, 31, 32'h0,        32'h0,        32'h0,        32'h0,        1, 1, 0, 0, 1};
    vecs[12] = '{1, 32'h00500093, 32'h124, 1, 0, 0, 32'h0,        1, 0, 0,  32'h0,        32'h0,        32'h0,        32'h0,        0, 0, 0, 0, 1};

    drive(0, 32'h0, 32'h0, 1, 0, 0, 0, 32'h0);
    reset = 1'b0;
    #1 reset = 1'b1;
    #2;
    check("reset_in_ready_a", bus_a.in_ready, 1'b0);
    check("reset_out_valid_a", bus_a.out_valid, 1'b0);
    check("reset_stall_a", stall_a, 32'h0);
    check("reset_pc_out_a", bus_a.pc_out, 32'h0);
    check("reset_out_valid_b", bus_b.out_valid, 1'b0);
    next_cycle();
    next_cycle();
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].v, vecs[i].ins, vecs[i].pc, 1'b1, vecs[i].fl, vecs[i].we, vecs[i].wid, vecs[i].wd);
      #1;
      check($sformatf("v%0d_in_ready_a", i), bus_a.in_ready, vecs[i].e_rdy);
      check($sformatf("v%0d_in_ready_b", i), bus_b.in_ready, vecs[i].e_rdy);
      next_cycle();
      check($sformatf("v%0d_out_valid_a", i), bus_a.out_valid, vecs[i].e_ov);
      check($sformatf("v%0d_out_valid_b", i), bus_b.out_valid, vecs[i].e_ov);
      check($sformatf("v%0d_stall_a", i), stall_a, vecs[i].e_stall);
      check($sformatf("v%0d_stall_b", i), stall_b, vecs[i].e_stall[1:0]);
      if (vecs[i].e_ov) begin
        check($sformatf("v%0d_rd_id", i), bus_a.rd_id, vecs[i].e_rd);
        check($sformatf("v%0d_imm", i), bus_a.immediate_data, vecs[i].e_imm);
        check($sformatf("v%0d_rd1", i), bus_a.read_data1, vecs[i].e_rd1);
        check($sformatf("v%0d_rd2", i), bus_a.read_data2, vecs[i].e_rd2);
        check($sformatf("v%0d_pc", i), bus_a.pc_out, vecs[i].pc);
        check($sformatf("v%0d_illegal_a", i), bus_a.instruction_illegal, vecs[i].e_ill);
        check($sformatf("v%0d_reg_write_a", i), bus_a.control_signals.reg_write, vecs[i].e_rw);
        check($sformatf("v%0d_rd2_b", i), bus_b.read_data2, vecs[i].e_rd2_b);
        check($sformatf("v%0d_illegal_b", i), bus_b.instruction_illegal, vecs[i].e_ill_b);
        check($sformatf("v%0d_reg_write_b", i), bus_b.control_signals.reg_write, vecs[i].e_rw_b);
      end
    end

    // Back-pressure: held addi x5,x0,7 must stay put while out_ready is low
    drive(1, 32'h00700293, 32'h200, 1, 0, 0, 0, 32'h0);
    next_cycle();
    drive(1, ADD_3_2_1, 32'h204, 0, 0, 0, 0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      #1;
      check("bp_in_ready", bus_a.in_ready, 1'b0);
      next_cycle();
      check("bp_out_valid", bus_a.out_valid, 1'b1);
      check("bp_rd_id", bus_a.rd_id, 5'd5);
      check("bp_imm", bus_a.immediate_data, 32'h7);
      check("bp_pc", bus_a.pc_out, 32'h200);
    end
    drive(1, ADD_3_2_1, 32'h204, 1, 0, 0, 0, 32'h0);
    #1;
    check("bp_release_in_ready", bus_a.in_ready, 1'b1);
    next_cycle();
    check("bp_next_rd_id", bus_a.rd_id, 5'd3);
    check("bp_next_pc", bus_a.pc_out, 32'h204);

    // Long load-use stall with execute blocked: counter saturation on dut_b
    drive(1, LW_2_0_1, 32'h208, 1, 0, 0, 0, 32'h0);
    next_cycle();
    drive(1, ADD_3_2_1, 32'h20C, 0, 0, 0, 0, 32'h0);
    for (int k = 0; k < 5; k++) begin
      #1;
      check("stall_in_ready", bus_a.in_ready, 1'b0);
      next_cycle();
    end
    check("stall_held_rd", bus_a.rd_id, 5'd2);
    check("stall_count_a", stall_a, 32'd6);
    check("stall_sat_b", stall_b, 2'd3);

    // Flush during hazard: ready overrides hazard, no count, output emptied
    drive(1, ADD_3_2_1, 32'h20C, 1, 1, 0, 0, 32'h0);
    #1;
    check("flush_in_ready", bus_a.in_ready, 1'b1);
    next_cycle();
    check("flush_out_valid_a", bus_a.out_valid, 1'b0);
    check("flush_out_valid_b", bus_b.out_valid, 1'b0);
    check("flush_stall_a", stall_a, 32'd6);

    // Asynchronous reset in the middle of a stall
    drive(1, LW_2_0_1, 32'h210, 1, 0, 0, 0, 32'h0);
    next_cycle();
    drive(1, ADD_3_2_1, 32'h214, 0, 0, 0, 0, 32'h0);
    next_cycle();
    check("pre_reset_stall_a", stall_a, 32'd7);
    reset = 1'b1;
    #1;
    check("async_reset_out_valid", bus_a.out_valid, 1'b0);
    check("async_reset_in_ready", bus_a.in_ready, 1'b0);
    check("async_reset_stall_a", stall_a, 32'd0);
    check("async_reset_stall_b", stall_b, 2'd0);
    check("async_reset_rd_id", bus_a.rd_id, 5'd0);
    next_cycle();
    reset = 1'b0;
    drive(0, 32'h0, 32'h0, 1, 0, 0, 0, 32'h0);
    next_cycle();
    check("post_reset_in_ready", bus_a.in_ready, 1'b1);
    check("post_reset_out_valid", bus_a.out_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
